// File: rtl/mem_access_pkg.sv
// mem_access_pkg: core types, funct3 constants and store-side helpers for the memory-access stage
package mem_access_pkg;

    localparam int cXLEN = 32;

    localparam logic [2:0] cLB  = 3'b000;
    localparam logic [2:0] cLH  = 3'b001;
    localparam logic [2:0] cLW  = 3'b010;
    localparam logic [2:0] cLBU = 3'b100;
    localparam logic [2:0] cLHU = 3'b101;
    localparam logic [2:0] cSB  = 3'b000;
    localparam logic [2:0] cSH  = 3'b001;
    localparam logic [2:0] cSW  = 3'b010;

    typedef struct packed {
        logic             dv;
        logic [4:0]       addr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    typedef struct packed {
        logic             isStore;
        logic [2:0]       funct3;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] wdata;
        logic [4:0]       rd;
    } tMemOp;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} tMemState;

    function automatic logic legalFunct3(input logic isStore, input logic [2:0] f);
        return isStore ? (f == cSB || f == cSH || f == cSW)
                       : (f == cLB || f == cLH || f == cLW || f == cLBU || f == cLHU);
    endfunction

    // Halves (xH/xHU) need addr[0]=0, words need addr[1:0]=0.
    function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
        return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [3:0] storeBe(input logic [2:0] f, input logic [1:0] a);
        return f == cSB ? 4'b0001 << a : f == cSH ? 4'b0011 << {a[1], 1'b0} : 4'hF;
    endfunction

    function automatic logic [cXLEN-1:0] storeData(input logic [2:0] f, input logic [cXLEN-1:0] d);
        return f == cSB ? {4{d[7:0]}} : f == cSH ? {2{d[15:0]}} : d;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/grant/response bus between the memory stage and data memory
interface mem_access_if;
    import mem_access_pkg::*;

    logic             req;
    logic             we;
    logic [cXLEN-1:0] addr;
    logic [3:0]       be;
    logic [cXLEN-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [cXLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half out of a load word and sign- or zero-extends it
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr,
    input  logic [cXLEN-1:0] rdata,
    output logic [cXLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Halves select on addr[1] only, so an unaligned half folds onto its aligned lane.
    always_comb begin
        b    = 8'(rdata >> {addr, 3'b000});
        h    = 16'(rdata >> {addr[1], 4'b0000});
        data = funct3 == cLB  ? {{24{b[7]}}, b}  :
               funct3 == cLH  ? {{16{h[15]}}, h} :
               funct3 == cLBU ? {24'd0, b}       :
               funct3 == cLHU ? {16'd0, h}       : rdata;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage; one load/store in flight on the dmem bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned halves/words instead of folding them aligned.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int pTimeout = 255
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    output logic         oReady,
    input  tMemOp        iMemOp,
    mem_access_if.master dmem,
    output tRegOp        oRdMem,
    output logic         oExc,
    output logic         oBusErr
);

    tMemState         state, nextState;
    tMemOp            op;
    logic [3:0]       be;
    logic [cXLEN-1:0] wdata;
    logic [cXLEN-1:0] loadData;
    logic [cXLEN-1:0] extData;
    logic [7:0]       cnt;
    logic             legal;
    logic             timeout;

`ifdef MEM_MISALIGN_TRAP_EN
    assign legal = legalFunct3(iMemOp.isStore, iMemOp.funct3) && !misaligned(iMemOp.funct3, iMemOp.addr[1:0]);
`else
    assign legal = legalFunct3(iMemOp.isStore, iMemOp.funct3);
`endif

    assign timeout = (cnt + 8'd1) == 8'(pTimeout);

    mem_load_align uAlign (
        .funct3 (op.funct3),
        .addr   (op.addr[1:0]),
        .rdata  (dmem.rdata),
        .data   (extData)
    );

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= IDLE;
        else       state <= nextState;
    end

    // Next state: grant/rvalid win over a timeout landing in the same cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = (iValid && legal) ? REQ : IDLE;
            REQ:     nextState = dmem.gnt ? (op.isStore ? IDLE : WAIT_R) : timeout ? IDLE : REQ;
            WAIT_R:  nextState = dmem.rvalid ? DONE : timeout ? IDLE : WAIT_R;
            default: nextState = IDLE;
        endcase
    end

    // Outputs: bus fields only driven while requesting, writeback only in DONE.
    always_comb begin
        oReady     = state == IDLE;
        dmem.req   = state == REQ;
        dmem.we    = state == REQ && op.isStore;
        dmem.addr  = state == REQ ? {op.addr[cXLEN-1:2], 2'b00} : '0;
        dmem.be    = state == REQ ? be : 4'h0;
        dmem.wdata = state == REQ && op.isStore ? wdata : '0;
        oRdMem     = state == DONE ? tRegOp'{op.rd != 5'd0, op.rd, loadData} : '0;
    end

    // Datapath: capture op on offer, wait counter, load result and error pulses.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            op       <= '0;
            be       <= '0;
            wdata    <= '0;
            loadData <= '0;
            cnt      <= '0;
            oExc     <= 1'b0;
            oBusErr  <= 1'b0;
        end else begin
            oExc    <= state == IDLE && iValid && !legal;
            oBusErr <= ((state == REQ && !dmem.gnt) || (state == WAIT_R && !dmem.rvalid)) && timeout;
            cnt     <= ((state == REQ || state == WAIT_R) && nextState == state) ? cnt + 8'd1 : '0;
            if (state == IDLE && iValid) begin
                op    <= iMemOp;
                be    <= iMemOp.isStore ? storeBe(iMemOp.funct3, iMemOp.addr[1:0]) : 4'hF;
                wdata <= storeData(iMemOp.funct3, iMemOp.wdata);
            end
            if (state == WAIT_R && dmem.rvalid) loadData <= extData;
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the integer pipeline: accepts one load/store per transaction from execute, drives the data-memory request/grant/response bus, and for loads returns a sign- or zero-extended result as a `tRegOp` write into the register file's memory write port. It sits between execute and the register file. It holds at most one access in flight, so execute stalls on `oReady`.

## Interface
- `pTimeout`, default 255: maximum cycles spent waiting in REQ or WAIT_R before a bus error; range 1..255.
- `iClk`  in  1  core clock.
- `iRst`  in  1  asynchronous reset, active-low.
- `iValid`  in  1  execute offers `iMemOp`.
- `oReady`  out  1  stage idle and able to accept.
- `iMemOp`  in  `tMemOp`  fields: `isStore`, `funct3[2:0]`, `addr[cXLEN-1:0]`, `wdata[cXLEN-1:0]`, `rd[4:0]`.
- `oDmemReq`  out  1  bus request.
- `oDmemWe`  out  1  1 = store.
- `oDmemAddr`  out  cXLEN  word-aligned address (`addr[1:0]` forced to 0).
- `oDmemBe`  out  4  byte enables.
- `oDmemWdata`  out  cXLEN  lane-replicated store data.
- `iDmemGnt`  in  1  request accepted this cycle.
- `iDmemRvalid`  in  1  load data valid.
- `iDmemRdata`  in  cXLEN  load data.
- `oRdMem`  out  `tRegOp`  register write: `dv`, `addr`, `data`.
- `oExc`  out  1  one-cycle pulse: misaligned or illegal funct3.
- `oBusErr`  out  1  one-cycle pulse: timeout.

## Operation
- States:
  - IDLE: `oReady`=1.
  - REQ: `oDmemReq`=1; bus outputs held stable.
  - WAIT_R: waiting for load data.
  - DONE: registered writeback.
- Transitions:
  - IDLE→REQ on `iValid`, when the op is legal and aligned.
  - REQ→IDLE on `iDmemGnt` for a store.
  - REQ→WAIT_R on `iDmemGnt` for a load.
  - WAIT_R→DONE on `iDmemRvalid`.
  - DONE→IDLE unconditionally.
- funct3 meaning:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Byte enables:
  - SB: `4'b0001<<addr[1:0]`.
  - SH: `4'b0011<<{addr[1],1'b0}`.
  - SW: `4'hF`.
  - Store data is replicated across lanes: byte ×4, half ×2.
- Load extraction:
  - Select the byte or half from `iDmemRdata` by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `oRdMem.dv`=1 only in DONE and only if `rd`≠0; `oRdMem.addr`=`rd`.
- Timeout: an 8-bit counter clears on entry to REQ and on entry to WAIT_R. When it reaches `pTimeout`:
  - pulse `oBusErr`;
  - drop `oDmemReq`;
  - go to IDLE with no writeback.
- `iDmemRvalid` is ignored outside WAIT_R. `iDmemGnt` is ignored outside REQ.

## Timing
- Reset values: state IDLE; `oReady`=1; `oDmemReq`=0; `oDmemWe`=0; `oDmemAddr`, `oDmemBe`, `oDmemWdata`=0; `oRdMem`=0; `oExc`=0; `oBusErr`=0; counter 0.
- Accept at edge T (`iValid`&&`oReady`): `oDmemReq` is high from T+1.
- Store with gnt at T+1: `oReady`=1 at T+2.
- Load with gnt at T+1 and rvalid at T+2 (minimum): `oRdMem.dv` at T+3, `oReady` at T+4.
- The bus must not assert rvalid in the same cycle as gnt.
- Illegal or misaligned op accepted at T: `oExc` pulses at T+1, no bus activity, `oReady` stays 1.
- Reset asserted mid-transaction aborts immediately: all outputs go to their reset values and no writeback occurs.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1 → `oExc`.
  - LW/SW with `addr[1:0]`≠0 → `oExc`.
- Not defined:
  - The offending low address bits are treated as 0: halves align to `addr[1]`, words to lane 0.
  - `oExc` is raised only for illegal funct3.

## Structure
- `corePckg` additions:
  - `tMemOp` struct;
  - `tMemState` enum {IDLE, REQ, WAIT_R, DONE};
  - funct3 constants `cLB`…`cLHU`, `cSB`…`cSW`.
- `tRegOp` and `cXLEN` are reused unchanged.
- One combinational sub-module, `mem_load_align`: inputs `funct3`, `addr[1:0]`, `rdata`; output is the extended data.

## Test plan
- SW `addr`=0x100, `wdata`=0xDEADBEEF, gnt same cycle as req → `oDmemBe`=0xF, `oDmemAddr`=0x100, `oDmemWe`=1; `oReady` high 2 cycles after accept.
- SB `addr`=0x103, `wdata`=0x000000A5 → `oDmemBe`=0x8, `oDmemWdata`=0xA5A5A5A5.
- LB `addr`=0x102, rd=5, rdata=0x00800000 → `oRdMem`={1,5,0xFFFFFF80}. LBU, same data → 0x00000080.
- LW with rd=0 → bus transaction occurs, `oRdMem.dv` stays 0.
- Gnt withheld for 255 cycles (`pTimeout`=255) → `oBusErr` pulse, `oDmemReq` low, `oReady` 1, no writeback.
- LH `addr`=0x101 → with the macro: `oExc` pulse and no `oDmemReq`. Without it: access at byte lane 0, rdata=0x0000F00F → 0xFFFFF00F.
